// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults.
// Imported by pc_reg and fetch_unit.
package fetch_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'd0;
  localparam logic [WORD_W-1:0] DEF_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter with load/hold/increment.
// Load wins over increment; wraps modulo 2^32.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_val,
  input  logic              inc,
  output logic [WORD_W-1:0] pc
);

  // PC update: redirect, sequential step, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register, BOOT/RUN/HOLD FSM.
// Define FETCH_PERF_EN to add fetch_cnt/stall_cnt counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] PC,
  input  logic [WORD_W-1:0] Instruction,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_instr,
  output logic              if_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic         adv;
  logic         flush;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (flush),
    .load_val (branch_addr),
    .inc      (adv),
    .pc       (PC)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; branch beats freeze, BOOT ignores freeze
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    flush   = 1'b0;
    if (branch_taken) begin
      flush   = 1'b1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (freeze) begin
            state_d = HOLD;
          end else begin
            adv = 1'b1;
          end
        end
        HOLD: begin
          if (!freeze) begin
            state_d = RUN;
            adv     = 1'b1;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // IF/ID register: flush, capture, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_instr <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (flush) begin
      if_instr <= '0;
      if_valid <= 1'b0;
    end else if (adv) begin
      if_instr <= Instruction;
      if_pc    <= PC + PC_STEP;
      if_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating fetch and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (adv && !(&fetch_cnt)) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (state_q == HOLD && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Works with or without FETCH_PERF_EN.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_chk;
  int n_fail;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PC           (PC),
    .Instruction  (Instruction),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_valid     (if_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   mem = 32'h00220000;
      32'h4:   mem = 32'h00640000;
      default: mem = {~a[15:0], a[15:0]};
    endcase
  endfunction

  assign Instruction = mem(PC);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: what the fetch stage must show after each edge
  logic [31:0] m_pc, m_instr, m_ifpc, m_fc, m_sc;
  logic        m_valid, m_boot, m_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 32'd0;
      m_instr <= 32'd0;
      m_ifpc  <= 32'd0;
      m_valid <= 1'b0;
      m_boot  <= 1'b1;
      m_hold  <= 1'b0;
      m_fc    <= 32'd0;
      m_sc    <= 32'd0;
    end else begin
      m_boot <= 1'b0;
      if (m_hold && m_sc != 32'hFFFFFFFF) m_sc <= m_sc + 1;
      if (branch_taken) begin
        m_pc    <= branch_addr;
        m_valid <= 1'b0;
        m_instr <= 32'd0;
        m_hold  <= 1'b0;
      end else if (m_boot) begin
        m_hold <= 1'b0;
      end else if (freeze) begin
        m_hold <= 1'b1;
      end else begin
        m_pc    <= m_pc + 32'd4;
        m_instr <= mem(m_pc);
        m_ifpc  <= m_pc + 32'd4;
        m_valid <= 1'b1;
        m_hold  <= 1'b0;
        m_fc    <= m_fc + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pc", PC, m_pc);
      chk("valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("instr", if_instr, m_instr);
      if (m_valid) chk("ifpc", if_pc, m_ifpc);
`ifdef FETCH_PERF_EN
      chk("fetch_cnt", fetch_cnt, m_fc);
      chk("stall_cnt", stall_cnt, m_sc);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;

    step();
    chk("rst_pc", PC, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_ifpc", if_pc, 32'd0);
    rst_n = 1'b1;

    // BOOT then sequential fetch
    step();
    chk("boot_pc", PC, 32'd0);
    chk("boot_valid", {31'd0, if_valid}, 32'd0);
    step();
    chk("seq_pc4", PC, 32'd4);
    chk("seq_i0", if_instr, 32'h00220000);
    chk("seq_ifpc4", if_pc, 32'd4);
    step();
    chk("seq_pc8", PC, 32'd8);
    chk("seq_i4", if_instr, 32'h00640000);
    chk("seq_ifpc8", if_pc, 32'd8);

    // Freeze three cycles at PC=8
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_pc", PC, 32'd8);
      chk("frz_instr", if_instr, 32'h00640000);
      chk("frz_ifpc", if_pc, 32'd8);
    end
    freeze = 1'b0;
    step();
    chk("resume_pc", PC, 32'd12);
    chk("resume_instr", if_instr, 32'hFFF70008);
    chk("resume_ifpc", if_pc, 32'd12);
`ifdef FETCH_PERF_EN
    chk("stall3", stall_cnt, 32'd3);
`endif

    // Branch overrides freeze
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    freeze       = 1'b1;
    step();
    chk("br_pc", PC, 32'h40);
    chk("br_flush", {31'd0, if_valid}, 32'd0);
    branch_taken = 1'b0;
    freeze       = 1'b0;
    step();
    chk("br_valid", {31'd0, if_valid}, 32'd1);
    chk("br_instr", if_instr, 32'hFFBF0040);
    chk("br_ifpc", if_pc, 32'h44);

    // Wrap at top of address space
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFFFFFC;
    step();
    chk("wrap_pc0", PC, 32'hFFFFFFFC);
    branch_taken = 1'b0;
    step();
    chk("wrap_pc1", PC, 32'd0);
    chk("wrap_ifpc", if_pc, 32'd0);
    chk("wrap_instr", if_instr, 32'h0003FFFC);

    // Run to PC=20, then asynchronous reset between edges
    for (int i = 0; i < 10 && PC !== 32'd20; i++) step();
    chk("reach_pc20", PC, 32'd20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", PC, 32'd0);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_instr", if_instr, 32'd0);

    // Release with freeze held: BOOT still one cycle
    step();
    freeze = 1'b1;
    rst_n  = 1'b1;
    step();
    chk("boot2_pc", PC, 32'd0);
    chk("boot2_valid", {31'd0, if_valid}, 32'd0);
    freeze = 1'b0;
    step();
    chk("boot2_run", PC, 32'd4);
    chk("boot2_instr", if_instr, 32'h00220000);
    step();

    // Branch during BOOT, unaligned target used as-is
    rst_n = 1'b0;
    step();
    rst_n        = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h103;
    step();
    chk("bootbr_pc", PC, 32'h103);
    chk("bootbr_valid", {31'd0, if_valid}, 32'd0);
    branch_taken = 1'b0;
    step();
    chk("bootbr_next", PC, 32'h107);
    chk("bootbr_instr", if_instr, 32'hFEFC0103);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd4: sequential address increment.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PC  output  32  fetch address driven to the instruction memory.
REQ-006 SHALL have port Instruction  input  32  combinational memory response for the current PC.
REQ-007 SHALL have port freeze  input  1  hazard stall: hold PC and the IF/ID register.
REQ-008 SHALL have port branch_taken  input  1  redirect fetch to branch_addr.
REQ-009 SHALL have port branch_addr  input  32  redirect target, byte address.
REQ-010 SHALL have port if_pc  output  32  registered address of the captured instruction plus PC_STEP.
REQ-011 SHALL have port if_instr  output  32  registered instruction (IF/ID).
REQ-012 SHALL have port if_valid  output  1  if_instr/if_pc hold a real instruction.

Function
REQ-013 SHALL implement FSM states BOOT, RUN, HOLD.
REQ-014 BOOT SHALL last exactly one cycle after reset release, with PC=RESET_PC and if_valid=0; then go to RUN.
REQ-015 In RUN with no freeze and no branch_taken, each edge SHALL set PC<=PC+PC_STEP, if_instr<=Instruction, if_pc<=PC+PC_STEP, and if_valid<=1.
REQ-016 Fetch latency SHALL be one cycle: the instruction at address A appears on if_instr on the edge after PC==A.
REQ-017 freeze=1 with branch_taken=0 SHALL hold PC, if_instr, if_pc and if_valid unchanged; the FSM goes to HOLD.
REQ-018 HOLD SHALL return to RUN on the first edge with freeze=0 and resume from the held PC with no instruction lost or duplicated.
REQ-019 branch_taken=1 SHALL override freeze in any state: PC<=branch_addr, if_valid<=0 (flush), if_instr<=0; the next state is RUN.
REQ-020 branch_addr SHALL be used as-is; bits [1:0] are not checked.
REQ-021 PC arithmetic SHALL be modulo 2^32; 32'hFFFFFFFC+4 wraps to 0 with no flag.
REQ-022 branch_taken during BOOT SHALL redirect; the BOOT fetch is discarded.
REQ-023 freeze during BOOT SHALL be ignored; BOOT always completes in one cycle.

Reset
REQ-024 While rst_n=0: PC=RESET_PC, if_instr=0, if_pc=0, if_valid=0, state=BOOT, all counters 0.
REQ-025 Reset asserted mid-operation SHALL take effect immediately, without a clock edge; in-flight IF/ID contents are lost.

Configuration
REQ-026 Macro FETCH_PERF_EN defined SHALL add outputs fetch_cnt [31:0] (+1 per edge with if_valid loaded 1) and stall_cnt [31:0] (+1 per HOLD cycle); both saturate at all-ones.
REQ-027 Macro FETCH_PERF_EN undefined SHALL remove those ports and counters completely; all other behaviour is identical.

Structure
REQ-028 Package fetch_pkg SHALL hold WORD_W=32, the default RESET_PC and PC_STEP, and typedef enum fetch_state_t {BOOT, RUN, HOLD}.
REQ-029 Sub-module pc_reg (PC register with load/hold/increment) SHALL be instantiated once; the IF/ID register and FSM stay in fetch_unit.

Verification
REQ-030 Reset, release, no stalls, memory returns 32'h00220000@0, 32'h00640000@4 -> PC sequence 0,0,4,8; if_instr=32'h00220000 with if_pc=4, then 32'h00640000 with if_pc=8.
REQ-031 freeze high 3 cycles while PC=8 -> PC, if_instr and if_pc frozen 3 cycles; resume at 8 with no gap; stall_cnt=3 when FETCH_PERF_EN is defined.
REQ-032 branch_taken=1, branch_addr=32'h40 together with freeze=1 at PC=12 -> next PC=32'h40, if_valid=0, then if_valid=1 with instruction @32'h40.
REQ-033 Branch to 32'hFFFFFFFC, run 2 cycles -> PC=32'hFFFFFFFC then 0; no error.
REQ-034 rst_n asserted asynchronously between edges at PC=20 -> PC=0, if_valid=0 immediately; after release, BOOT repeats.
REQ-035 Build with and without FETCH_PERF_EN -> identical PC/if_* traces for REQ-030..033.
